// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the write-back path: the result payload and a round-robin index helper.
package wb_arbiter_pkg;

  localparam int DEST_W = 7;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } result_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, zero latency.
// Pure function of its inputs; stalling is the caller's job.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = int'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        gnt_any = 1'b1;
      end
      j = rr_next(j, N);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// N result ports, each queued, share one register-file write port; grant to write output is 1 cycle.
// Per-port ready drops only when that port's queue is full; wb_stall blocks new grants, never retracts a write.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  result_t [N-1:0]     result,
  input  logic [N-1:0]        result_valid,
  output logic [N-1:0]        result_ready,
  input  logic                wb_stall,
  output logic                write_en,
  output logic [DEST_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                busy
);

  localparam int PW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              armed_q, armed_d;
  logic [N-1:0]      push_vld;
  logic [N-1:0]      pop_vld;
  logic [N-1:0]      req_vld;
  result_t           head [N];

  logic [N-1:0]      gnt;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              grant;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic              write_en_q, write_en_d;
  logic [DEST_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // Ready is held low for the first edge after reset so nothing is accepted before the queues settle.
  assign armed_d = 1'b1;
  assign grant   = gnt_any & ~wb_stall;
  assign pop_vld = grant ? gnt : '0;

  for (genvar i = 0; i < N; i++) begin : g_queue
    result_t       mem_q [DEPTH];
    result_t       mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign result_ready[i] = armed_q & ~reset & (cnt_q != CW'(DEPTH));
    assign push_vld[i]     = result_valid[i] & result_ready[i];
    assign req_vld[i]      = (cnt_q != '0);
    assign head[i]         = mem_q[rd_ptr_q];

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_vld[i]) begin
        mem_d[wr_ptr_q] = result[i];
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_vld[i]) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_vld[i], pop_vld[i]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[k] <= '0;
        end
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  rr_arbiter #(.N(N)) u_rr (
    .req     (req_vld),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = '0;
    write_data_d = '0;
    ptr_d        = ptr_q;
    if (grant) begin
      write_en_d   = 1'b1;
      write_addr_d = head[gnt_idx].dest;
      write_data_d = head[gnt_idx].data;
      ptr_d        = PW'(rr_next(int'(gnt_idx), N));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q      <= 1'b0;
      ptr_q        <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      armed_q      <= armed_d;
      ptr_q        <= ptr_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign busy       = (|req_vld) | write_en_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus saturating random traffic checked against per-port expected queues.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  result_t [N-1:0] result;
  logic [N-1:0]    result_valid;
  logic [N-1:0]    result_ready;
  logic            wb_stall;
  logic            write_en;
  logic [6:0]      write_addr;
  logic [31:0]     write_data;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t     obs_q [$];
  result_t exp_q [N][$];

  wb_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .wb_stall     (wb_stall),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && write_en) obs_q.push_back(wr_t'{cyc, write_addr, write_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    result_valid = '0;
    result       = '0;
    wb_stall     = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    checks++; if (result_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %h want 0", result_ready); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", write_en); end
    checks++; if (write_addr !== 7'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", write_addr); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", write_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b0;
    #1;
    checks++; if (result_ready !== 4'h0) begin errors++; $display("FAIL rst_ready_pre_edge: got %h want 0", result_ready); end
    tick();
    checks++; if (result_ready !== 4'hF) begin errors++; $display("FAIL rst_ready_after_edge: got %h want f", result_ready); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_no_write: got %b want 0", write_en); end
  endtask

  task automatic test_single();
    result[2]       = result_t'{dest: 7'd5, data: 32'hDEADBEEF};
    result_valid[2] = 1'b1;
    checks++; if (result_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", result_ready[2]); end
    tick();
    result_valid = '0;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", write_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL single_wen: got %b want 1", write_en); end
    checks++; if (write_addr !== 7'd5) begin errors++; $display("FAIL single_addr: got %h want 05", write_addr); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", write_data); end
    tick();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", write_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    obs_q.delete();
  endtask

  task automatic test_all_ports();
    result_t exp_ord [$];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      result[i] = result_t'{dest: 7'(16 + i), data: 32'(i)};
      exp_ord.push_back(result[i]);
    end
    result_valid = '1;
    tick();
    result_valid = '0;
    wait_writes(4, 20);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL all_count: got %0d want 4", obs_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].addr !== exp_ord[k].dest || obs_q[k].data !== exp_ord[k].data) begin
        errors++;
        $display("FAIL all_order[%0d]: got %h/%h want %h/%h", k, obs_q[k].addr, obs_q[k].data, exp_ord[k].dest, exp_ord[k].data);
      end
      if (k > 0) begin
        checks++;
        if (obs_q[k].cyc != obs_q[k-1].cyc + 1) begin
          errors++;
          $display("FAIL all_consecutive[%0d]: got cycle %0d want %0d", k, obs_q[k].cyc, obs_q[k-1].cyc + 1);
        end
      end
    end
    obs_q.delete();
  endtask

  // Runs right after test_all_ports, so the pointer should be back at 0: port 0 must precede port 3.
  task automatic test_stall();
    wb_stall  = 1'b1;
    result[0] = result_t'{dest: 7'd1, data: 32'hA0};
    result[3] = result_t'{dest: 7'd2, data: 32'hA3};
    result_valid = 4'b1001;
    tick();
    result_valid = '0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL stall_wen[%0d]: got %b want 0", k, write_en); end
      tick();
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    wb_stall = 1'b0;
    wait_writes(2, 10);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[0].data !== 32'hA0 || obs_q[0].addr !== 7'd1) begin errors++; $display("FAIL stall_first: got %h/%h want 01/a0", obs_q[0].addr, obs_q[0].data); end
      checks++; if (obs_q[1].data !== 32'hA3 || obs_q[1].addr !== 7'd2) begin errors++; $display("FAIL stall_second: got %h/%h want 02/a3", obs_q[1].addr, obs_q[1].data); end
    end
    tick();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    result_t ent [3];
    int k;
    ent[0] = result_t'{dest: 7'd3, data: 32'hB0};
    ent[1] = result_t'{dest: 7'd4, data: 32'hB1};
    ent[2] = result_t'{dest: 7'd5, data: 32'hB2};
    wb_stall        = 1'b1;
    result_valid[1] = 1'b1;
    for (int e = 0; e < 2; e++) begin
      result[1] = ent[e];
      checks++; if (result_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_accept[%0d]: got %b want 1", e, result_ready[1]); end
      tick();
    end
    result[1] = ent[2];
    checks++; if (result_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", result_ready[1]); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (result_ready[1] !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL b2b_hold[%0d]: got ready %b wen %b want 0 0", c, result_ready[1], write_en); end
    end
    wb_stall = 1'b0;
    k = 0;
    while (!result_ready[1] && k < 10) begin
      tick();
      k++;
    end
    checks++; if (result_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b want 1", result_ready[1]); end
    tick();
    result_valid = '0;
    wait_writes(3, 20);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", obs_q.size()); end
    for (int e = 0; e < 3 && e < obs_q.size(); e++) begin
      checks++;
      if (obs_q[e].addr !== ent[e].dest || obs_q[e].data !== ent[e].data) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got %h/%h want %h/%h", e, obs_q[e].addr, obs_q[e].data, ent[e].dest, ent[e].data);
      end
    end
    repeat (2) tick();
    obs_q.delete();
  endtask

  task automatic test_random();
    int           seq [N];
    int           last [N];
    int           p1_start, p1_end, p, k;
    logic [N-1:0] xfer;
    result_t      e;
    obs_q.delete();
    for (int i = 0; i < N; i++) begin
      seq[i]    = 0;
      last[i]   = -1;
      result[i] = result_t'{dest: 7'($urandom), data: {4'(i), 28'(0)}};
      exp_q[i].delete();
    end
    result_valid = '1;
    wb_stall     = 1'b0;
    p1_start     = cyc;
    p1_end       = cyc;
    for (int c = 0; c < 900; c++) begin
      xfer = result_valid & result_ready;
      for (int i = 0; i < N; i++) if (xfer[i]) exp_q[i].push_back(result[i]);
      tick();
      for (int i = 0; i < N; i++) begin
        if (xfer[i]) begin
          seq[i]++;
          result[i] = result_t'{dest: 7'($urandom), data: {4'(i), 28'(seq[i])}};
        end
      end
      if (c < 450) begin
        result_valid = '1;
        wb_stall     = 1'b0;
        p1_end       = cyc;
      end else begin
        for (int i = 0; i < N; i++) result_valid[i] = ($urandom_range(0, 3) != 0);
        wb_stall = ($urandom_range(0, 4) == 0);
      end
    end
    result_valid = '0;
    wb_stall     = 1'b0;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain: busy %b want 0", busy); end
    repeat (2) tick();
    for (int w = 0; w < obs_q.size(); w++) begin
      p = int'(obs_q[w].data[31:28]);
      checks++;
      if (p >= N || exp_q[p].size() == 0) begin
        errors++;
        $display("FAIL rand_extra: unexpected write %h/%h", obs_q[w].addr, obs_q[w].data);
      end else begin
        e = exp_q[p].pop_front();
        if (obs_q[w].addr !== e.dest || obs_q[w].data !== e.data) begin
          errors++;
          $display("FAIL rand_order port %0d: got %h/%h want %h/%h", p, obs_q[w].addr, obs_q[w].data, e.dest, e.data);
        end
        if (obs_q[w].cyc <= p1_end) begin
          if (obs_q[w].cyc > p1_start + 12 && last[p] >= 0) begin
            checks++;
            if (obs_q[w].cyc - last[p] > N) begin
              errors++;
              $display("FAIL rand_gap port %0d: got gap %0d want <= %0d", p, obs_q[w].cyc - last[p], N);
            end
          end
          last[p] = obs_q[w].cyc;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (exp_q[i].size() != 0) begin errors++; $display("FAIL rand_lost port %0d: got %0d unwritten want 0", i, exp_q[i].size()); end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int k;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) result[i] = result_t'{dest: 7'(40 + i), data: 32'(32'hC0 + i)};
    result_valid = 4'b0111;
    repeat (2) tick();
    result_valid = '0;
    wb_stall     = 1'b0;
    k = 0;
    while (!write_en && k < 10) begin
      tick();
      k++;
    end
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL mid_wen_pre: got %b want 1", write_en); end
    #1;
    reset = 1'b1;
    obs_q.delete();
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_wen: got %b want 0", write_en); end
    checks++; if (write_addr !== 7'h0 || write_data !== 32'h0) begin errors++; $display("FAIL mid_outputs: got %h/%h want 0/0", write_addr, write_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (result_ready !== 4'h0) begin errors++; $display("FAIL mid_ready: got %h want 0", result_ready); end
    repeat (2) tick();
    reset = 1'b0;
    checks++; if (result_ready !== 4'h0) begin errors++; $display("FAIL mid_ready_pre_edge: got %h want 0", result_ready); end
    tick();
    checks++; if (result_ready !== 4'hF) begin errors++; $display("FAIL mid_ready_return: got %h want f", result_ready); end
    repeat (10) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_no_writes: got %0d writes want 0", obs_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_all_ports();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
